// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered binary-to-Gray stage among NREQ requesters.
// Optional parity output enabled by defining GRAY_CONV_PARITY_EN.
module gray_conv_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*W-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      out_valid,
  output logic [W-1:0]              out_gray,
  output logic [$clog2(NREQ)-1:0]   out_id,
`ifdef GRAY_CONV_PARITY_EN
  output logic                      out_par,
`endif
  input  logic                      out_ready,
  output logic                      busy
);
  localparam int IDW = $clog2(NREQ);

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    to_gray = b ^ (b >> 1);
  endfunction

  function automatic logic parity_of(input logic [W-1:0] b);
    parity_of = ^b;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_gray_q, out_gray_d;
  logic [IDW-1:0]   out_id_q, out_id_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [NREQ-1:0]  winner_s;
  logic [IDW-1:0]   win_id_s;
  logic             found_s;
  logic             can_accept_s;
  logic             xfer_s;
  logic [W-1:0]     sel_data_s;
  int               idx_s;
`ifdef GRAY_CONV_PARITY_EN
  logic             out_par_q, out_par_d;
`endif

  // Find the first valid requester after last_grant, wrapping modulo NREQ.
  always_comb begin
    winner_s = '0;
    win_id_s = '0;
    found_s  = 1'b0;
    idx_s    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = (int'(last_grant_q) + k) % NREQ;
      if (!found_s && req_valid[idx_s]) begin
        found_s         = 1'b1;
        winner_s[idx_s] = 1'b1;
        win_id_s        = IDW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign can_accept_s = ~out_valid_q | out_ready;
  assign req_ready    = winner_s & {NREQ{can_accept_s & rst_n}};
  assign xfer_s       = |(req_valid & req_ready);
  assign sel_data_s   = req_data[int'(win_id_s)*W +: W];
  assign busy         = out_valid_q | (|req_valid);

  // Output register next state: load on transfer, clear valid on pure drain, else hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_gray_d   = out_gray_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
`ifdef GRAY_CONV_PARITY_EN
    out_par_d    = out_par_q;
`endif
    if (xfer_s) begin
      out_valid_d  = 1'b1;
      out_gray_d   = to_gray(sel_data_s);
      out_id_d     = win_id_s;
      last_grant_d = win_id_s;
`ifdef GRAY_CONV_PARITY_EN
      out_par_d    = parity_of(sel_data_s);
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset; pointer starts so requester 0 leads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_gray_q   <= '0;
      out_id_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
`ifdef GRAY_CONV_PARITY_EN
      out_par_q    <= 1'b0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_gray_q   <= out_gray_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
`ifdef GRAY_CONV_PARITY_EN
      out_par_q    <= out_par_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_gray  = out_gray_q;
  assign out_id    = out_id_q;
`ifdef GRAY_CONV_PARITY_EN
  assign out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter (NREQ=4, W=4).
module tb_gray_conv_arbiter;
  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_gray;
  logic [1:0]  out_id;
  logic        out_ready;
  logic        busy;
`ifdef GRAY_CONV_PARITY_EN
  logic        out_par;
`endif

  int total;
  int bad;

  gray_conv_arbiter #(.NREQ(4), .W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_id    (out_id),
`ifdef GRAY_CONV_PARITY_EN
    .out_par   (out_par),
`endif
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_gray [4];
  logic       rr_par  [4];

  initial begin
    total = 0;
    bad   = 0;
    rr_gray[0] = 4'b0011; rr_gray[1] = 4'b0101; rr_gray[2] = 4'b1110; rr_gray[3] = 4'b1000;
    rr_par[0]  = 1'b1;    rr_par[1]  = 1'b0;    rr_par[2]  = 1'b1;    rr_par[3]  = 1'b0;

    // reset held two cycles, a valid request must not see ready
    rst_n = 1'b0; req_valid = 4'b0001; req_data = 16'h0005; out_ready = 1'b1;
    step(); step();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_gray", 32'(out_gray), 32'h0);
    check("rst_id", 32'(out_id), 32'h0);

    // single request
    rst_n = 1'b1; #1;
    check("single_ready", 32'(req_ready), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    step();
    req_valid = 4'b0000;
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_gray", 32'(out_gray), 32'h7);
    check("single_id", 32'(out_id), 32'h0);
    step();
    check("drain_valid", 32'(out_valid), 32'h0);
    check("drain_hold", 32'(out_gray), 32'h7);
    check("drain_busy", 32'(busy), 32'h0);

    // round robin from a fresh pointer
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req_data  = {4'b1111, 4'b1011, 4'b0110, 4'b0010};
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(4'b0001 << k));
      step();
      req_valid[k] = 1'b0;
      check("rr_valid", 32'(out_valid), 32'h1);
      check("rr_gray", 32'(out_gray), 32'(rr_gray[k]));
      check("rr_id", 32'(out_id), 32'(k));
`ifdef GRAY_CONV_PARITY_EN
      check("rr_par", 32'(out_par), 32'(rr_par[k]));
`endif
    end
    check("rr_busy_last", 32'(busy), 32'h1);
    step();
    check("rr_drained", 32'(out_valid), 32'h0);
    check("rr_busy_idle", 32'(busy), 32'h0);

    // backpressure: load 1110 from requester 2, then stall with requester 1 pending
    req_valid = 4'b0100;
    step();
    check("bp_load", 32'(out_gray), 32'he);
    out_ready = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'h0);
      step();
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_gray", 32'(out_gray), 32'he);
      check("bp_id", 32'(out_id), 32'h2);
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", 32'(req_ready), 32'h2);
    step();
    check("bp_nobubble", 32'(out_valid), 32'h1);
    check("bp_gray2", 32'(out_gray), 32'h5);
    check("bp_id2", 32'(out_id), 32'h1);

    // pointer fairness: set last_grant=2, then 0101 wraps to 0, then 2
    req_valid = 4'b0100; #1;
    check("pf_set", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0101; #1;
    check("pf_wrap_ready", 32'(req_ready), 32'h1);
    step();
    check("pf_wrap_id", 32'(out_id), 32'h0);
    #1;
    check("pf_next_ready", 32'(req_ready), 32'h4);
    step();
    check("pf_next_id", 32'(out_id), 32'h2);

    // reset during a stalled output
    out_ready = 1'b0; req_valid = 4'b0000;
    step();
    check("mr_pre_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    step();
    check("mr_valid", 32'(out_valid), 32'h0);
    check("mr_gray", 32'(out_gray), 32'h0);
    check("mr_id", 32'(out_id), 32'h0);
`ifdef GRAY_CONV_PARITY_EN
    check("mr_par", 32'(out_par), 32'h0);
`endif
    rst_n = 1'b1; out_ready = 1'b1; req_valid = 4'b1111; #1;
    check("mr_first_ready", 32'(req_ready), 32'h1);
    step();
    check("mr_first_id", 32'(out_id), 32'h0);
    check("mr_first_gray", 32'(out_gray), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Round-robin arbiter that shares one binary-to-Gray conversion stage between NREQ requesters.
- Each requester offers a W-bit binary word over a valid/ready handshake.
- The winner's word is converted (MSB passed through; bit i = b[i+1]^b[i]), registered, and presented on a single valid/ready output tagged with the requester index.
- Sits between the counter/pointer sources and downstream consumers that need Gray-coded values.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 4, binary/Gray word width (>=2).
- IDW, $clog2(NREQ), width of requester index tag (derived localparam, not overridable).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  per-requester valid.
- req_data  input  NREQ*W  packed binary words; requester i at [i*W +: W].
- req_ready  output  NREQ  per-requester ready; at most one bit high per cycle.
- out_valid  output  1  converted word available.
- out_gray  output  W  registered Gray word.
- out_id  output  IDW  index of the requester that produced out_gray.
- out_ready  input  1  downstream accepts the output word.
- busy  output  1  high while out_valid=1 or any req_valid=1.

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_gray=0, out_id=0, and the round-robin pointer last_grant=NREQ-1 (requester 0 has top priority first).
- While rst_n=0, req_ready=0.
- Reset mid-transfer discards any held output word; no partial word survives.
- can_accept = ~out_valid | out_ready (single output register with pass-through on drain).
- Grant (combinational):
  - Search requesters starting at last_grant+1 and wrapping modulo NREQ.
  - The first i with req_valid[i]=1 wins.
  - req_ready[i] = winner[i] & can_accept & rst_n.
- Transfer on requester i: req_valid[i] & req_ready[i].
  - Next edge: out_valid=1, out_gray=gray(req_data[i]), out_id=i, last_grant=i.
- Latency: exactly 1 cycle from accepted request to out_valid. Throughput: 1 word/cycle when out_ready is held high.
- Output drain: out_valid & out_ready with no new transfer in the same cycle -> out_valid=0; out_gray and out_id hold their last values.
- Simultaneous drain and accept in the same cycle: the output register reloads with the new word, out_valid stays 1, no bubble.
- Stall: out_valid & ~out_ready -> out_gray and out_id are stable, all req_ready=0, last_grant is frozen.
- last_grant changes only on a transfer. A requester dropping valid before being granted does not move the pointer.
- Requesters must hold req_valid and req_data stable until their req_ready. The arbiter does not latch unaccepted inputs.
- Fairness: with all NREQ requesters continuously valid and out_ready=1, grants rotate 0,1,..,NREQ-1,0,...; each requester is served within NREQ transfers.
- Conversion is purely bitwise on W bits with no overflow cases. Input 0 maps to 0; input 2^W-1 maps to 1 followed by W-1 zeros.
- busy is combinational from out_valid and req_valid.

Optional Feature:
- Macro: GRAY_CONV_PARITY_EN.
- When defined:
  - Extra output port out_par (1 bit) = XOR of all req_data bits of the accepted word (equal to the LSB-weighted parity of the binary input).
  - Registered alongside out_gray; reset value 0; held during stalls.
- When undefined: the port does not exist and there is no extra logic.

Test Plan:
- Reset then single request: rst_n=0 for 2 cycles, then req_valid=4'b0001, req_data[3:0]=4'b0101, out_ready=1 -> req_ready=4'b0001 in the same cycle; next cycle out_valid=1, out_gray=4'b0111, out_id=0.
- Round robin: all four valid with data 4'b0010, 4'b0110, 4'b1011, 4'b1111, out_ready=1 -> grants 0,1,2,3 on consecutive cycles; out_gray sequence 0011, 0101, 1110, 1000; out_id 0,1,2,3; busy drops after the last output drains.
- Backpressure: out_valid=1 holding 4'b1110, out_ready=0 for 5 cycles with req1 valid -> out_gray, out_id and last_grant unchanged; req_ready=0. Raise out_ready -> req1 is granted in that cycle and out_valid stays 1 with no bubble.
- Pointer fairness: last_grant=2, req_valid=4'b0101 -> requester 0 wins (wrap); then with req_valid=4'b0101 still set -> requester 2 wins.
- Mid-operation reset: out_valid=1 with out_ready=0, assert rst_n=0 for 1 cycle -> out_valid=0, out_gray=0, out_id=0; the first grant after reset goes to requester 0.
- GRAY_CONV_PARITY_EN defined: accept 4'b1011 -> out_par=1; accept 4'b0110 -> out_par=0.
